// File: rtl/id_ex_skid_reg_pkg.sv
// Shared RV32I decode/execute types for the ID/EX boundary register.
package id_ex_skid_reg_pkg;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
  } rv32i_control_word;

  typedef struct packed {
    rv32i_control_word ctrl;
    rv32i_word         immediate;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    rv32i_word         pc;
    rv32i_word         instr_data;
  } rv32i_instr_word;

  // Encoding doubles as the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute boundary: two-entry skid buffer carrying the packed
// instruction word, with the head entry also exposed field by field.
//
// state | meaning
// EMPTY | nothing held, out_valid low, main zeroed
// ONE   | head word in main
// TWO   | head in main, next word parked in skid (SKID_EN=1 only)
module id_ex_skid_reg
  import id_ex_skid_reg_pkg::*;
#(
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  rv32i_instr_word   in_word,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output rv32i_instr_word   out_word,
  output rv32i_control_word out_ctrl,
  output logic [31:0]       out_immediate,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr_data,
  output logic [1:0]        occupancy
);

  skid_state_t     state;
  rv32i_instr_word main_q;
  rv32i_instr_word skid_q;
  logic            ready_q;
  logic            in_fire;
  logic            out_fire;

  // ready_q holds in_ready low during reset and for the remainder of the
  // cycle in which reset is released.
  assign in_ready  = ready_q & (SKID_EN ? (state != TWO) : (!out_valid | out_ready));
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (flush) begin
        state  <= EMPTY;
        main_q <= '0;
        skid_q <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_q <= in_word;
              state  <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_q <= in_word;
            end else if (in_fire && SKID_EN) begin
              skid_q <= in_word;
              state  <= TWO;
            end else if (out_fire) begin
              main_q <= '0;
              state  <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_q <= skid_q;
              skid_q <= '0;
              state  <= ONE;
            end
          end
          default: begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
          end
        endcase
      end
    end
  end

  // main is zeroed whenever the stage empties, so fields read 0 when invalid.
  assign out_word       = main_q;
  assign out_ctrl       = main_q.ctrl;
  assign out_immediate  = main_q.immediate;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_rd         = main_q.rd;
  assign out_pc         = main_q.pc;
  assign out_instr_data = main_q.instr_data;

endmodule
